mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle main controller; sits directly upstream of the ALU and datapath.
//  Decodes the fetched instruction and steps through FETCH/DECODE/EXEC/MEM/WB states.
//  Drives every datapath enable and mux select, including the 2-bit ALUOp
//  (00 add, 01 sub, 10 or). Supports addu, subu, ori, lui, lw, sw, beq and j.
//  Waits on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock; all state changes on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   6      instr[31:26], from IR
//  funct        in   6      instr[5:0], from IR
//  zero         in   1      datapath (ALU result == 0) flag
//  mem_ready    in   1      memory completes access this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if zero==1 (beq)
//  IorD         out  1      mem address: 0 PC, 1 ALUOut
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  IRWrite      out  1      load IR
//  RegDst       out  1      write reg: 0 rt, 1 rd
//  MemtoReg     out  1      write data: 0 ALUOut, 1 MDR
//  RegWrite     out  1      register-file write
//  ALUSrcA      out  1      0 PC, 1 reg A
//  ALUSrcB      out  2      00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ExtOp        out  2      00 zero-ext, 01 sign-ext, 10 imm<<16 (lui)
//  ALUOp        out  2      00 add, 01 sub, 10 or
//  PCSource     out  2      00 ALU result, 01 ALUOut, 10 jump target
//  illegal      out  1      one-cycle pulse on an unsupported opcode/funct
//  retired      out  CNT_W  count of completed instructions, wraps mod 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=INIT, retired=0. INIT decodes all outputs to 0.
//  - INIT -> FETCH unconditionally on the first clock after reset release.
//  - Outputs are Moore-decoded from the state. Exceptions: PCWrite and IRWrite in
//    FETCH, and the exits of FETCH/MEM_RD/MEM_WR, are gated by mem_ready.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//    PCWrite and IRWrite are asserted only when mem_ready=1.
//    State is held while mem_ready=0, then -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=01, ALUOp=00 (branch target).
//    Dispatch: lw/sw -> MEM_ADR; R/ori/lui -> EXEC; beq -> BRANCH; j -> JUMP;
//    else pulse illegal and go -> FETCH (instruction acts as a nop, not retired).
//  - MEM_ADR: ALUSrcA=1, ALUSrcB=10, ExtOp=01, ALUOp=00. lw -> MEM_RD, sw -> MEM_WR.
//  - MEM_RD: MemRead=1, IorD=1; hold until mem_ready, then -> MEM_WB.
//  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
//  - MEM_WR: MemWrite=1, IorD=1; hold until mem_ready, then -> FETCH.
//  - EXEC, ALUSrcA=1:
//      addu: ALUSrcB=00, ALUOp=00.   subu: ALUSrcB=00, ALUOp=01.
//      ori: ALUSrcB=10, ExtOp=00, ALUOp=10.   lui: ALUSrcB=10, ExtOp=10, ALUOp=00.
//    Next state -> ALU_WB.
//  - ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type, 0 for ori/lui -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
//  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  - Cycle counts with mem_ready=1: beq/j 3, sw/addu/subu/ori/lui 4, lw 5.
//    Each mem_ready=0 cycle adds one cycle.
//  - retired increments on the last cycle of every legal instruction.
//    Last cycle = MEM_WB, MEM_WR(ready), ALU_WB, BRANCH, JUMP. Wraps to 0.
//  - Any output not listed for a state is 0.
//  - Reset mid-instruction: async return to INIT; no write strobe survives reset.
// STRUCTURE
//  - Shared package mc_pkg: state encoding, opcode/funct constants,
//    ALUOp/ALUSrcB/ExtOp/PCSource encodings (shared with ALU and datapath).
//  - Sub-module mc_ctrl_decode: purely combinational map
//    (state, opcode, funct, mem_ready) -> control word.
//  - The top holds the state register, next-state logic and the retired counter.
// TESTING
//  - Reset: rst_n=0 mid-FETCH -> all outputs 0, retired=0; one clock after
//    release -> FETCH with MemRead=1.
//  - addu (opcode 000000, funct 100001), mem_ready=1:
//    4 cycles; EXEC ALUOp=00; ALU_WB RegWrite=1, RegDst=1; retired 0->1.
//  - lw (100011) with mem_ready low 2 cycles in MEM_RD:
//    7 cycles total; MemRead/IorD held; one RegWrite pulse with MemtoReg=1.
//  - beq (000100): zero=1 -> PCWriteCond=1, ALUOp=01 in BRANCH.
//    zero=0 -> same strobes; both cases 3 cycles.
//  - ori (001101) -> ExtOp=00, ALUOp=10. lui (001111) -> ExtOp=10, ALUOp=00.
//  - Illegal opcode 111111 -> illegal pulses in DECODE, back to FETCH,
//    retired unchanged, no RegWrite/MemWrite.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller, ALU and datapath:
// state names, opcode/funct values, mux/ALU select codes and the control word.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEM_ADR = 4'd3,
        ST_MEM_RD  = 4'd4,
        ST_MEM_WB  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_EXEC    = 4'd7,
        ST_ALU_WB  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_t;

    typedef enum logic [2:0] {
        CLS_MEM     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        ext_op_t    ext_op;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       illegal;
    } ctrl_word_t;

    // Anything not in the supported subset (including R-type with other funct codes) is illegal.
    function automatic instr_class_t classify(input logic [5:0] opcode, input logic [5:0] funct);
        instr_class_t cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    cls = CLS_ALU;
                end
            end
            OP_ORI, OP_LUI: cls = CLS_ALU;
            OP_LW, OP_SW:   cls = CLS_MEM;
            OP_BEQ:         cls = CLS_BRANCH;
            OP_J:           cls = CLS_JUMP;
            default:        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode: state plus the fields of the current IR
// (and mem_ready for the FETCH-time PC/IR load) to every datapath strobe and select.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.pc_write  = mem_ready;
                cw.ir_write  = mem_ready;
            end
            ST_DECODE: begin
                cw.alu_src_b = SRCB_IMM_SH2;
                cw.ext_op    = EXT_SIGN;
                cw.illegal   = (classify(opcode, funct) == CLS_ILLEGAL);
            end
            ST_MEM_ADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.ext_op    = EXT_SIGN;
            end
            ST_MEM_RD: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                cw.mem_write = 1'b1;
                cw.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                cw.alu_src_a = 1'b1;
                // Only addu/subu/ori/lui can reach EXEC, so the R-type case only needs funct to pick sub.
                case (opcode)
                    OP_ORI: begin
                        cw.alu_src_b = SRCB_IMM;
                        cw.ext_op    = EXT_ZERO;
                        cw.alu_op    = ALU_OR;
                    end
                    OP_LUI: begin
                        cw.alu_src_b = SRCB_IMM;
                        cw.ext_op    = EXT_LUI;
                        cw.alu_op    = ALU_ADD;
                    end
                    default: begin
                        cw.alu_src_b = SRCB_REG;
                        cw.alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    end
                endcase
            end
            ST_ALU_WB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = (opcode == OP_RTYPE);
            end
            ST_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRCB_REG;
                cw.alu_op        = ALU_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PCSRC_JUMP;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: state register, instruction-class dispatch,
// memory-ready stalls and the retired-instruction counter.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ExtOp,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    ctrl_word_t       cw;
    instr_class_t     cls;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // The beq decision is taken in the datapath via PCWriteCond; zero is carried for interface symmetry.
    logic unused_zero;
    assign unused_zero = zero;

    assign cls = classify(opcode, funct);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_FETCH;
            ST_FETCH:   state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (cls)
                    CLS_MEM:    state_d = ST_MEM_ADR;
                    CLS_ALU:    state_d = ST_EXEC;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    CLS_JUMP:   state_d = ST_JUMP;
                    default:    state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:  state_d = ST_FETCH;
            ST_MEM_WR:  state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC:    state_d = ST_ALU_WB;
            ST_ALU_WB:  state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            default:    state_d = ST_INIT;
        endcase
    end

    // Count on the final cycle of each legal instruction; illegal ones fall out of DECODE uncounted.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP: retire = 1'b1;
            ST_MEM_WR:                                retire = mem_ready;
            default:                                  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .funct     (funct),
        .mem_ready (mem_ready),
        .cw        (cw)
    );

    assign PCWrite     = cw.pc_write;
    assign PCWriteCond = cw.pc_write_cond;
    assign IorD        = cw.i_or_d;
    assign MemRead     = cw.mem_read;
    assign MemWrite    = cw.mem_write;
    assign IRWrite     = cw.ir_write;
    assign RegDst      = cw.reg_dst;
    assign MemtoReg    = cw.mem_to_reg;
    assign RegWrite    = cw.reg_write;
    assign ALUSrcA     = cw.alu_src_a;
    assign ALUSrcB     = cw.alu_src_b;
    assign ExtOp       = cw.ext_op;
    assign ALUOp       = cw.alu_op;
    assign PCSource    = cw.pc_source;
    assign illegal     = cw.illegal;
    assign retired     = retired_q;

endmodule
